// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encodings and a
// counter-width helper.
package bit_serializer_pkg;

   // 2-bit state encodings. S_LOAD is the single capture clock between the
   // accepted handshake and the first bit period.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   // Counter width for a modulus n. Never returns less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider. It counts DIV clocks per period and reports the end of
// the current period. It also looks one clock ahead: whether the next clock
// starts a period and whether the next clock ends one. The look-ahead lets
// the parent register its outputs without adding latency.
//  clk          in  system clock
//  rst_n        in  async active-low reset
//  restart      in  sync clear; the next clock is the first of a period
//  end_c        out current clock is the last of its period
//  next_start_c out next clock is the first of a period
//  next_end_c   out next clock is the last of a period
module bit_tick_gen
   import bit_serializer_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic end_c,
   output logic next_start_c,
   output logic next_end_c
);

   localparam int unsigned    CW   = clog2_min1(DIV);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // The terminal count returns to zero on the same edge, so the counter never wraps.
   always_comb begin
      cnt_nxt = cnt + CW'(1);
      if (restart || cnt == LAST) begin
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   assign end_c        = (cnt == LAST);
   assign next_start_c = (cnt_nxt == '0);
   assign next_end_c   = (cnt_nxt == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the downstream detector stage. It accepts a
// word over a LOAD/READY handshake and sends it MSB first on I, one bit per
// DIV-clock period. EN strobes on the first clock of each bit period. An
// optional GAP of idle clocks follows each word.
//  CLK   in  system clock
//  RST_N in  async active-low reset
//  D     in  parallel word, captured when LOAD & READY
//  LOAD  in  word-valid request
//  READY out block accepts a word this clock
//  EN    out bit strobe
//  I     out serial data bit
//  BUSY  out word in flight (SHIFT or GAP)
//  DONE  out pulse on the last clock of the last bit
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 1,
   parameter int unsigned GAP   = 0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD,
   output logic             READY,
   output logic             EN,
   output logic             I,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned    BW       = clog2_min1(WIDTH);
   localparam int unsigned    GW       = clog2_min1(GAP);
   localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_nxt;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    bit_nxt;
   logic [GW-1:0]    gap_cnt;
   logic [GW-1:0]    gap_nxt;
   logic             restart_c;
   logic             end_c;
   logic             next_start_c;
   logic             next_end_c;

   // The divider runs only while shifting, so every word starts on a fresh period.
   assign restart_c = (state != S_SHIFT);

   bit_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk          (CLK),
      .rst_n        (RST_N),
      .restart      (restart_c),
      .end_c        (end_c),
      .next_start_c (next_start_c),
      .next_end_c   (next_end_c)
   );

   // Next-state, shift register and counter logic.
   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      bit_nxt   = '0;
      gap_nxt   = '0;
      case (state)
         S_IDLE: begin
            if (LOAD) begin
               state_nxt = S_LOAD;
               sh_nxt    = D;
            end
         end
         S_LOAD: begin
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            bit_nxt = bit_cnt;
            if (end_c) begin
               sh_nxt = {sh[WIDTH-2:0], 1'b0};
               if (bit_cnt == BIT_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
               end else begin
                  bit_nxt = bit_cnt + BW'(1);
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               gap_nxt = gap_cnt + GW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         sh      <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         sh      <= sh_nxt;
         bit_cnt <= bit_nxt;
         gap_cnt <= gap_nxt;
      end
   end

   // Outputs are registered from next-state values, so they line up with the state they describe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         READY <= 1'b1;
         BUSY  <= 1'b0;
         EN    <= 1'b0;
         I     <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         READY <= (state_nxt == S_IDLE);
         BUSY  <= (state_nxt == S_SHIFT) || (state_nxt == S_GAP);
         EN    <= (state_nxt == S_SHIFT) && next_start_c;
         I     <= (state_nxt == S_SHIFT) && sh_nxt[WIDTH-1];
         DONE  <= (state_nxt == S_SHIFT) && (bit_nxt == BIT_LAST) && next_end_c;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer. It runs three instances side by side:
// (DIV=1, GAP=0), (DIV=4, GAP=0) and (DIV=1, GAP=3).
// A word-level model predicts every output on every clock. The model tracks
// the clocks elapsed since each accepted word and derives the outputs from
// that count.
module tb_bit_serializer;

   localparam int W = 8;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b1;
   logic [7:0] d     [3];
   logic       ld    [3];
   logic       rdy   [3];
   logic       bsy   [3];
   logic       en_o  [3];
   logic       i_o   [3];
   logic       dn    [3];

   int divs [3] = '{1, 4, 1};
   int gaps [3] = '{0, 0, 3};

   // model state
   bit         act  [3];
   int         pos  [3];
   logic [7:0] word [3];
   int         nacc [3];

   // observation accumulators
   logic [63:0] acc [3];
   int          nb  [3];
   int          cyc;
   int          first_en1;
   int          done1;
   int          gapcnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   bit_serializer #(.WIDTH(8), .DIV(1), .GAP(0)) u0 (
      .CLK(CLK), .RST_N(RST_N), .D(d[0]), .LOAD(ld[0]), .READY(rdy[0]),
      .EN(en_o[0]), .I(i_o[0]), .BUSY(bsy[0]), .DONE(dn[0]));
   bit_serializer #(.WIDTH(8), .DIV(4), .GAP(0)) u1 (
      .CLK(CLK), .RST_N(RST_N), .D(d[1]), .LOAD(ld[1]), .READY(rdy[1]),
      .EN(en_o[1]), .I(i_o[1]), .BUSY(bsy[1]), .DONE(dn[1]));
   bit_serializer #(.WIDTH(8), .DIV(1), .GAP(3)) u2 (
      .CLK(CLK), .RST_N(RST_N), .D(d[2]), .LOAD(ld[2]), .READY(rdy[2]),
      .EN(en_o[2]), .I(i_o[2]), .BUSY(bsy[2]), .DONE(dn[2]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected {READY,BUSY,EN,I,DONE} for instance k.
   function automatic logic [4:0] expect_of(int k);
      int span;
      int b;
      int ph;
      span = W * divs[k];
      if (!act[k]) return 5'b10000;
      if (pos[k] == 0) return 5'b00000;
      if (pos[k] <= span) begin
         b  = (pos[k] - 1) / divs[k];
         ph = (pos[k] - 1) % divs[k];
         return {1'b0, 1'b1, ph == 0, word[k][7-b], pos[k] == span};
      end
      return 5'b01000;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) act[k] = 1'b0;
   endtask

   // Advance the model by one clock edge, using the inputs presented before the edge.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (!RST_N) begin
            act[k] = 1'b0;
         end else if (!act[k]) begin
            if (ld[k]) begin
               act[k]  = 1'b1;
               pos[k]  = 0;
               word[k] = d[k];
               nacc[k]++;
            end
         end else begin
            pos[k]++;
            if (pos[k] > W * divs[k] + gaps[k]) act[k] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      logic [4:0] got;
      for (int k = 0; k < 3; k++) begin
         got = {rdy[k], bsy[k], en_o[k], i_o[k], dn[k]};
         check_eq($sformatf("u%0d rdy_bsy_en_i_done", k), 64'(got), 64'(expect_of(k)));
         if (en_o[k]) begin
            acc[k] = {acc[k][62:0], i_o[k]};
            nb[k]++;
         end
      end
      if (en_o[1] && first_en1 < 0) first_en1 = cyc;
      if (dn[1]) done1 = cyc;
      if (bsy[2] && !en_o[2]) gapcnt2++;
   endtask

   task automatic clear_obs();
      for (int k = 0; k < 3; k++) begin
         acc[k] = '0;
         nb[k]  = 0;
      end
      first_en1 = -1;
      done1     = -1;
      gapcnt2   = 0;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      cyc++;
      #1;
      check_all();
   endtask

   task automatic pulse_reset();
      #2 RST_N = 1'b0;
      #1;
      model_reset();
      check_all();
      step();
      RST_N = 1'b1;
      check_all();
   endtask

   initial begin
      cyc = 0;
      for (int k = 0; k < 3; k++) begin
         ld[k] = 1'b0; d[k] = '0; nacc[k] = 0; act[k] = 1'b0; pos[k] = 0; word[k] = '0;
      end
      clear_obs();

      // reset before the first clock edge, then release
      #1 RST_N = 1'b0;
      #1;
      model_reset();
      check_all();
      step();
      step();
      RST_N = 1'b1;
      check_all();

      // directed: A5 on u0, 81 on u1 (DIV=4), FF then 00 with LOAD held on u2 (GAP=3)
      clear_obs();
      ld[0] = 1'b1; d[0] = 8'hA5;
      ld[1] = 1'b1; d[1] = 8'h81;
      ld[2] = 1'b1; d[2] = 8'hFF;
      for (int c = 0; c < 45; c++) begin
         step();
         if (c == 0) begin
            ld[0] = 1'b0; ld[1] = 1'b0; d[2] = 8'h00;
         end
         if (c == 2) d[1] = 8'h55;
         if (c == 3) begin
            ld[0] = 1'b1; d[0] = 8'h3C;
         end
         if (c == 4) ld[0] = 1'b0;
         if (nacc[2] == 2) ld[2] = 1'b0;
      end
      check_eq("u0 stream A5", acc[0], 64'hA5);
      check_eq("u0 bit count", 64'(nb[0]), 64'd8);
      check_eq("u1 stream 81", acc[1], 64'h81);
      check_eq("u1 bit count", 64'(nb[1]), 64'd8);
      check_eq("u1 first EN to DONE", 64'(done1 - first_en1), 64'(W * 4 - 1));
      check_eq("u2 stream FF00", acc[2], 64'hFF00);
      check_eq("u2 bit count", 64'(nb[2]), 64'd16);
      check_eq("u2 gap clocks", 64'(gapcnt2), 64'd6);

      // reset during bit 4 of F0, then a clean 0F
      clear_obs();
      ld[0] = 1'b1; d[0] = 8'hF0;
      step();
      ld[0] = 1'b0;
      for (int c = 0; c < 5; c++) step();
      check_eq("u0 bits before reset", acc[0], 64'h1E);
      pulse_reset();
      clear_obs();
      ld[0] = 1'b1; d[0] = 8'h0F;
      step();
      ld[0] = 1'b0;
      for (int c = 0; c < 11; c++) step();
      check_eq("u0 stream 0F after reset", acc[0], 64'h0F);
      check_eq("u0 bit count after reset", 64'(nb[0]), 64'd8);

      // random traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         step();
         for (int k = 0; k < 3; k++) begin
            ld[k] = ($urandom_range(0, 2) == 0);
            d[k]  = 8'($urandom);
         end
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
